// File: rtl/dpram_pkt_reader.sv
// Read-side requester for port B of the dual-port packet RAM: walks a descriptor, hides RAM latency
// in a 2-entry buffer, streams words with a last marker. Optional packet counter: DPRAM_PKT_RD_STAT_EN.
module dpram_pkt_reader #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              req_valid_in,
    output logic              req_ready_out,
    input  logic [AWIDTH-1:0] req_addr_in,
    input  logic [AWIDTH:0]   req_len_in,
    output logic              en_b_out,
    output logic              we_b_out,
    output logic [AWIDTH-1:0] addr_b_out,
    input  logic [DWIDTH-1:0] d_b_in,
    output logic              m_valid_out,
    input  logic              m_ready_in,
    output logic [DWIDTH-1:0] m_data_out,
    output logic              m_last_out,
    output logic              busy_out
`ifdef DPRAM_PKT_RD_STAT_EN
    ,
    output logic [15:0]       pkt_cnt_out
`endif
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_e;

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [AWIDTH:0]   rem_q, rem_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;
    logic [DWIDTH-1:0] buf_data_q [2];
    logic [1:0]        buf_last_q;
    logic              rd_ptr_q, rd_ptr_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic [1:0]        buf_cnt_q, buf_cnt_d;

    logic       push, pop, issue, last_pop;
    logic [1:0] occ;

    assign push        = inflight_q;
    assign m_valid_out = (buf_cnt_q != 2'd0);
    assign m_data_out  = buf_data_q[rd_ptr_q];
    assign m_last_out  = buf_last_q[rd_ptr_q];
    assign pop         = m_valid_out && m_ready_in;
    assign last_pop    = pop && m_last_out;

    // Credit: words buffered plus the one in flight, minus this cycle's pop, must leave a free slot.
    assign occ   = buf_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    assign issue = rst_n_in && (state_q == READ) && (rem_q != '0) && (occ < 2'd2);

    assign en_b_out      = issue;
    assign we_b_out      = 1'b0;
    assign addr_b_out    = addr_q;
    assign req_ready_out = (state_q == IDLE) && rst_n_in;
    assign busy_out      = (state_q != IDLE);

    // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        rem_d           = rem_q;
        inflight_d      = issue;
        inflight_last_d = issue && (rem_q == (AWIDTH+1)'(1));
        rd_ptr_d        = rd_ptr_q ^ pop;
        wr_ptr_d        = wr_ptr_q ^ push;
        buf_cnt_d       = buf_cnt_q + {1'b0, push} - {1'b0, pop};

        unique case (state_q)
            IDLE: begin
                if (req_valid_in && (req_len_in != '0)) begin
                    addr_d  = req_addr_in;
                    rem_d   = req_len_in;
                    state_d = READ;
                end
            end
            READ: begin
                if (issue) begin
                    addr_d = addr_q + AWIDTH'(1);
                    rem_d  = rem_q - (AWIDTH+1)'(1);
                    if (rem_q == (AWIDTH+1)'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_pop) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            buf_cnt_q       <= 2'd0;
            // NOTE: the two buffer entries are reset because the head drives m_data_out directly.
            buf_data_q[0]   <= '0;
            buf_data_q[1]   <= '0;
            buf_last_q      <= 2'b00;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            rem_q           <= rem_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            buf_cnt_q       <= buf_cnt_d;
            if (push) begin
                buf_data_q[wr_ptr_q] <= d_b_in;
                buf_last_q[wr_ptr_q] <= inflight_last_q;
            end
        end
    end

`ifdef DPRAM_PKT_RD_STAT_EN
    logic [15:0] pkt_cnt_q;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            pkt_cnt_q <= 16'h0000;
        end else if (last_pop && (pkt_cnt_q != 16'hFFFF)) begin
            pkt_cnt_q <= pkt_cnt_q + 16'h0001;
        end
    end

    assign pkt_cnt_out = pkt_cnt_q;
`endif

endmodule
